wallace_pipe_mul: RTL and testbench

Parametrised, pipelined Wallace-tree multiplier; the successor to the fixed 32-bit combinational `wallace` block. Operand width, pipeline depth and per-transaction signed/unsigned mode are configurable, and operands flow through a valid/ready handshake with full backpressure. It sits in the datapath wherever a registered full-width product is needed at one result per cycle.

---
 rtl/wallace_pipe_mul.sv | 127 ++++++++++++
 tb/tb_wallace_pipe_mul.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_pipe_mul.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per bundle; STAGES cycles latency.
// All ranks shift together when the output is empty or consumed, so a stall freezes the whole pipe.
module wallace_pipe_mul #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic [TAG_W-1:0]     out_tag
);
   localparam int PW   = 2 * WIDTH;
   localparam int ROWS = WIDTH + 1;
   localparam int LVLS = 12;

   logic          adv;
   logic [PW-1:0] tree_sum;
   logic [PW-1:0] tree_car;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Row WIDTH holds the Baugh-Wooley correction constant (2^WIDTH + 2^(2*WIDTH-1)).
   always_comb begin
      logic [PW-1:0] red [ROWS];
      logic [PW-1:0] nxt [ROWS];
      int            n;
      int            m;
      for (int r = 0; r < ROWS; r++) begin
         red[r] = '0;
         nxt[r] = '0;
      end
      for (int i = 0; i < WIDTH; i++)
         for (int j = 0; j < WIDTH; j++)
            red[i][i+j] = (in_a[j] & in_b[i]) ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
      if (in_signed) begin
         red[WIDTH][WIDTH] = 1'b1;
         red[WIDTH][PW-1]  = 1'b1;
      end
      n = ROWS;
      for (int l = 0; l < LVLS; l++) begin
         if (n > 2) begin
            for (int r = 0; r < ROWS; r++) nxt[r] = '0;
            m = 0;
            for (int k = 0; k + 2 < n; k += 3) begin
               nxt[m]   = red[k] ^ red[k+1] ^ red[k+2];
               nxt[m+1] = ((red[k] & red[k+1]) | (red[k] & red[k+2]) | (red[k+1] & red[k+2])) << 1;
               m += 2;
            end
            for (int k = n - (n % 3); k < n; k++) begin
               nxt[m] = red[k];
               m++;
            end
            for (int r = 0; r < ROWS; r++) red[r] = nxt[r];
            n = m;
         end
      end
      tree_sum = red[0];
      tree_car = red[1];
   end

   generate
      if (STAGES == 1) begin : g_one
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid <= 1'b0;
               out_p     <= '0;
               out_tag   <= '0;
            end else if (adv) begin
               out_valid <= in_valid;
               out_p     <= tree_sum + tree_car;
               out_tag   <= in_tag;
            end
         end
      end else begin : g_multi
         // Carry-save pair is registered right after the tree; the carry-propagate add feeds the output rank.
         localparam int MID = STAGES - 1;
         logic             vld [MID];
         logic [TAG_W-1:0] tag [MID];
         logic [PW-1:0]    sum [MID];
         logic [PW-1:0]    car [MID];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < MID; k++) vld[k] <= 1'b0;
            end else if (adv) begin
               vld[0] <= in_valid;
               for (int k = 1; k < MID; k++) vld[k] <= vld[k-1];
            end
         end

         always_ff @(posedge clk) begin
            if (adv) begin
               tag[0] <= in_tag;
               sum[0] <= tree_sum;
               car[0] <= tree_car;
               for (int k = 1; k < MID; k++) begin
                  tag[k] <= tag[k-1];
                  sum[k] <= sum[k-1];
                  car[k] <= car[k-1];
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid <= 1'b0;
               out_p     <= '0;
               out_tag   <= '0;
            end else if (adv) begin
               out_valid <= vld[MID-1];
               out_p     <= sum[MID-1] + car[MID-1];
               out_tag   <= tag[MID-1];
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_wallace_pipe_mul.sv
// Directed vectors on the default configuration plus a width/depth sweep against a behavioural product.
module tb_wallace_pipe_mul;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic go    = 1'b0;
   always #5 clk = ~clk;

   int n_chk      = 0;
   int n_pass     = 0;
   int sweep_done = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   logic        in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [63:0] out_p;

   wallace_pipe_mul #(.WIDTH(32), .STAGES(3), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] p;
   } vec_t;

   vec_t single_v [6] = '{
      '{32'd19,        32'd15,        1'b0, 64'h0000_0000_0000_011D},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001},
      '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001},
      '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000},
      '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000}};

   vec_t b2b_v [6] = '{
      '{32'd7,         32'd6,         1'b0, 64'h0000_0000_0000_002A},
      '{32'hFFFF_FFFF, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFFB},
      '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1, 64'h0000_0000_0000_000C},
      '{32'hFFFF_FFFF, 32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE},
      '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000}};

   vec_t bp_v [5] = '{
      '{32'd100,       32'd200,       1'b0, 64'h0000_0000_0000_4E20},
      '{32'hFFFF_FFF9, 32'd9,         1'b1, 64'hFFFF_FFFF_FFFF_FFC1},
      '{32'hDEAD_BEEF, 32'd1,         1'b0, 64'h0000_0000_DEAD_BEEF},
      '{32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000},
      '{32'h1234_5678, 32'h10,        1'b0, 64'h0000_0001_2345_6780}};

   task automatic run_single(input vec_t v, input logic [3:0] tg);
      @(negedge clk);
      in_valid = 1'b1; in_a = v.a; in_b = v.b; in_signed = v.s; in_tag = tg;
      @(negedge clk);
      in_valid = 1'b0;
      check("single_early1", out_valid, 1'b0);
      @(negedge clk);
      check("single_early2", out_valid, 1'b0);
      @(negedge clk);
      check("single_vld", out_valid, 1'b1);
      check("single_p", out_p, v.p);
      check("single_tag", out_tag, tg);
   endtask

   initial begin
      int rx, idx, stall, stale;
      logic took, started;
      logic [63:0] hold_p;
      logic [3:0]  hold_t;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_vld", out_valid, 1'b0);
      check("rst_p", out_p, 64'h0);
      check("rst_tag", out_tag, 4'h0);
      rst_n = 1'b1;
      go    = 1'b1;
      #1 check("rst_rdy", in_ready, 1'b1);

      for (int i = 0; i < 6; i++) run_single(single_v[i], 4'(i + 1));

      rx = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c < 6) begin
            in_valid = 1'b1; in_a = b2b_v[c].a; in_b = b2b_v[c].b;
            in_signed = b2b_v[c].s; in_tag = 4'(c);
         end else in_valid = 1'b0;
         #1;
         if (c < 6) check("b2b_rdy", in_ready, 1'b1);
         if (out_valid) begin
            if (rx < 6) begin
               check("b2b_cycle", c, rx + 3);
               check("b2b_tag", out_tag, rx);
               check("b2b_p", out_p, b2b_v[rx].p);
            end
            rx++;
         end
      end
      check("b2b_count", rx, 6);

      rx = 0; idx = 0; stall = 0; took = 1'b0; started = 1'b0; hold_p = '0; hold_t = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (took) idx++;
         in_valid = (idx < 5);
         if (idx < 5) begin
            in_a = bp_v[idx].a; in_b = bp_v[idx].b; in_signed = bp_v[idx].s; in_tag = 4'(idx + 8);
         end
         if (out_valid && !started) begin
            started = 1'b1; stall = 4; hold_p = out_p; hold_t = out_tag;
         end
         out_ready = (stall == 0);
         #1;
         if (stall > 0) begin
            if (stall == 4) check("bp_rdy_drop", in_ready, 1'b0);
            else begin
               check("bp_hold_p", out_p, hold_p);
               check("bp_hold_tag", out_tag, hold_t);
               check("bp_hold_vld", out_valid, 1'b1);
            end
            stall--;
         end
         took = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (rx < 5) begin
               check("bp_p", out_p, bp_v[rx].p);
               check("bp_tag", out_tag, rx + 8);
            end
            rx++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_count", rx, 5);

      for (int c = 0; c < 3000 && sweep_done < 12; c++) @(negedge clk);
      check("sweep_done", sweep_done, 12);

      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 32'(c + 2); in_b = 32'd3; in_signed = 1'b0; in_tag = 4'(c + 1);
      end
      #1;
      check("rst_pre_vld", out_valid, 1'b1);
      check("rst_pre_p", out_p, 64'd6);
      check("rst_pre_tag", out_tag, 4'd1);
      #1 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_mid_vld", out_valid, 1'b0);
      check("rst_mid_p", out_p, 64'h0);
      check("rst_mid_tag", out_tag, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_post_rdy", in_ready, 1'b1);
      stale = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("rst_stale", stale, 0);
      run_single('{32'd7, 32'd9, 1'b0, 64'd63}, 4'hA);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   for (genvar gw = 0; gw < 4; gw++) begin : g_w
      for (genvar gs = 0; gs < 3; gs++) begin : g_s
         localparam int SW = (gw == 0) ? 4 : (gw == 1) ? 8 : (gw == 2) ? 17 : 64;
         localparam int SS = (gs == 0) ? 1 : (gs == 1) ? 2 : 6;
         logic            sv, srdy, ssg, sov, sr;
         logic [SW-1:0]   sa, sb;
         logic [3:0]      stg, stgo;
         logic [2*SW-1:0] sp;

         wallace_pipe_mul #(.WIDTH(SW), .STAGES(SS), .TAG_W(4)) u_mul (
            .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(srdy),
            .in_a(sa), .in_b(sb), .in_signed(ssg), .in_tag(stg),
            .out_valid(sov), .out_ready(sr), .out_p(sp), .out_tag(stgo));

         initial begin : drv
            logic [2*SW-1:0] q_p [$];
            logic [3:0]      q_t [$];
            int              q_c [$];
            logic [63:0]     ra, rb;
            logic [2*SW-1:0] ea, eb;
            string           nm;
            nm = $sformatf("sw_w%0d_s%0d", SW, SS);
            sv = 1'b0; sr = 1'b1; sa = '0; sb = '0; ssg = 1'b0; stg = '0;
            wait (go);
            for (int c = 0; c < 8 + SS + 4; c++) begin
               @(negedge clk);
               if (sov) begin
                  if (q_p.size() > 0) begin
                     check({nm, "_p"}, sp, q_p.pop_front());
                     check({nm, "_tag"}, stgo, q_t.pop_front());
                     check({nm, "_lat"}, c, q_c.pop_front() + SS);
                  end else check({nm, "_extra"}, sov, 1'b0);
               end
               if (c < 8) begin
                  check({nm, "_rdy"}, srdy, 1'b1);
                  ra = {$urandom(), $urandom()};
                  rb = {$urandom(), $urandom()};
                  sa = ra[SW-1:0];
                  sb = rb[SW-1:0];
                  ssg = 1'($urandom_range(0, 1));
                  if (c == 0) begin sa = '1; sb = '1; ssg = 1'b1; end
                  if (c == 1) begin sa = '0; sa[SW-1] = 1'b1; sb = sa; ssg = 1'b1; end
                  stg = 4'(c + 3);
                  sv  = 1'b1;
                  ea = ssg ? {{SW{sa[SW-1]}}, sa} : {{SW{1'b0}}, sa};
                  eb = ssg ? {{SW{sb[SW-1]}}, sb} : {{SW{1'b0}}, sb};
                  q_p.push_back(ea * eb);
                  q_t.push_back(stg);
                  q_c.push_back(c);
               end else sv = 1'b0;
            end
            check({nm, "_drain"}, q_p.size(), 0);
            sweep_done++;
         end
      end
   end
endmodule
